spk_out: RTL

- Sits directly downstream of the soma stage in each node.
- Captures per-neuron fire decisions during a soma update sweep and buffers fired neuron indices in a small FIFO.
- For each fired neuron, emits one spike flit per enabled entry of a node-level destination table onto the router injection port, using a valid/ready handshake.

---
 rtl/spk_pkg.sv | 37 +++
 rtl/spk_fifo.sv | 53 +++++
 rtl/spk_out.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spk_pkg.sv
// Shared constants for the spike output stage: field widths, flit layout,
// FSM encoding and a helper that packs a spike flit.
package spk_pkg;

    localparam int FW        = 59;
    localparam int FTW       = 3;
    localparam int NNW       = 12;
    localparam int DST_WIDTH = 21;
    localparam int DST_DEPTH = 4;
    localparam int DST_AW    = $clog2(DST_DEPTH);
    localparam int FIFO_AW   = 4;
    localparam int CNTW      = 16;

    localparam logic [FTW-1:0] FLIT_SPK = 3'b001;

    localparam int FLIT_TYPE_LSB = FW - FTW;
    localparam int FLIT_DST_LSB  = FLIT_TYPE_LSB - DST_WIDTH;
    localparam int FLIT_NID_LSB  = 0;
    localparam int DST_FLG       = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } spk_state_e;

    // Bits between the destination field and the neuron index stay zero.
    function automatic logic [FW-1:0] spk_flit(input logic [DST_WIDTH-1:0] dst,
                                               input logic [NNW-1:0]       nid);
        logic [FW-1:0] f;
        f = '0;
        f[FLIT_TYPE_LSB +: FTW]      = FLIT_SPK;
        f[FLIT_DST_LSB +: DST_WIDTH] = dst;
        f[FLIT_NID_LSB +: NNW]       = nid;
        return f;
    endfunction

endpackage

// File: rtl/spk_fifo.sv
// Small synchronous FIFO holding fired neuron indices; head is readable
// combinationally so the sender can load it in the same cycle it pops.
module spk_fifo #(
    parameter int W  = 12,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/spk_out.sv
// Spike output stage: buffers fired neuron indices and fans each one out to
// every enabled destination-table entry as a flit on the router port.
module spk_out
    import spk_pkg::*;
(
    input  logic                 clk_spk_out,
    input  logic                 rst_n,
    input  logic                 soma_spk_out_vld,
    input  logic                 soma_spk_out_fire,
    input  logic [NNW-1:0]       soma_spk_out_nid,
    input  logic                 config_spk_enable,
    input  logic                 config_spk_clear,
    input  logic                 config_dst_we,
    input  logic [DST_AW-1:0]    config_dst_waddr,
    input  logic [DST_WIDTH-1:0] config_dst_wdata,
    output logic                 spk_out_flit_vld,
    output logic [FW-1:0]        spk_out_flit,
    input  logic                 spk_out_flit_rdy,
    output logic                 spk_out_busy,
    output logic                 spk_out_overflow,
    output logic [CNTW-1:0]      spk_out_cnt
);

    localparam logic [DST_AW-1:0] IDX_LAST = DST_AW'(DST_DEPTH - 1);

    logic                 push_req;
    logic                 push_acc;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [NNW-1:0]       fifo_dout;
    spk_state_e           state_q, state_d;
    logic [NNW-1:0]       nid_q, nid_d;
    logic [DST_AW-1:0]    idx_q, idx_d;
    logic [DST_WIDTH-1:0] dst_tbl [DST_DEPTH];
    logic [DST_WIDTH-1:0] entry;
    logic                 flit_vld;
    logic                 advance;
    logic                 busy;
    logic                 ovf_q;
    logic [CNTW-1:0]      cnt_q;

    assign push_req = soma_spk_out_vld && soma_spk_out_fire && config_spk_enable;
    assign push_acc = push_req && (!fifo_full || pop);
    assign busy     = !fifo_empty || (state_q != IDLE);
    assign entry    = dst_tbl[idx_q];

    spk_fifo #(
        .W  (NNW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_spk_out),
        .rst_n (rst_n),
        .push  (push_acc),
        .pop   (pop),
        .din   (soma_spk_out_nid),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Table writes are locked out while busy so an in-flight flit never changes.
    for (genvar gi = 0; gi < DST_DEPTH; gi++) begin : g_tbl
        logic [DST_WIDTH-1:0] ent_q;
        always_ff @(posedge clk_spk_out or negedge rst_n) begin
            if (!rst_n) begin
                ent_q <= '0;
            end else if (config_dst_we && !busy && (config_dst_waddr == DST_AW'(gi))) begin
                ent_q <= config_dst_wdata;
            end
        end
        assign dst_tbl[gi] = ent_q;
    end

    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nid_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            nid_q   <= nid_d;
            idx_q   <= idx_d;
        end
    end

    // Disabled entries cost one cycle each; the last entry chains straight
    // into the next buffered neuron without returning to IDLE.
    always_comb begin
        state_d  = state_q;
        nid_d    = nid_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        flit_vld = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    nid_d   = fifo_dout;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                flit_vld = entry[DST_FLG];
                advance  = !entry[DST_FLG] || spk_out_flit_rdy;
                if (advance) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop   = 1'b1;
                        nid_d = fifo_dout;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (config_spk_clear) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_acc)              cnt_q <= cnt_q + 1'b1;
            if (push_req && !push_acc) ovf_q <= 1'b1;
        end
    end

    assign spk_out_flit_vld = flit_vld;
    assign spk_out_flit     = flit_vld ? spk_flit(entry, nid_q) : '0;
    assign spk_out_busy     = busy;
    assign spk_out_overflow = ovf_q;
    assign spk_out_cnt      = cnt_q;

endmodule
